dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_if.sv | 25 ++
 rtl/dmem_responder.sv | 152 +++++++++++++++
 tb/tb_dmem_responder.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// Data-memory request/response bundle between the pipeline MEM stage and the
// data-memory responder.
//   master : pipeline side, drives MemRead/MemWrite/RW_type/addr/Wr_mem_data
//            and receives loaddata/mem_stall/access_err
//   slave  : memory side, the mirror image
interface dmem_if;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  RW_type;
    logic [31:0] addr;
    logic [31:0] Wr_mem_data;
    logic [31:0] loaddata;
    logic        mem_stall;
    logic        access_err;

    modport master (
        output MemRead, MemWrite, RW_type, addr, Wr_mem_data,
        input  loaddata, mem_stall, access_err
    );

    modport slave (
        input  MemRead, MemWrite, RW_type, addr, Wr_mem_data,
        output loaddata, mem_stall, access_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Byte-addressable little-endian data memory for a pipeline MEM stage.
// Aligned loads complete combinationally, aligned stores write at the next
// edge. An access that crosses a word boundary takes two cycles: the first
// stalls the pipeline and handles word A, the second handles word A+1.
//   clk    : single clock, rising edge
//   rst_n  : synchronous active-low reset (array contents are preserved)
//   bus    : dmem_if.slave -- request in, loaddata/mem_stall/access_err out
// DEPTH_WORDS must be a power of two between 2 and 256 so that the word
// index is a plain slice of addr[9:2] and word A+1 wraps naturally.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | accepting requests; aligned accesses finish here, a misaligned
//        | one stalls, buffers/writes word A and moves on
// SECOND | finishing a misaligned access on word A+1, then back to IDLE
module dmem_responder #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic   clk,
    input  logic   rst_n,
    dmem_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic {IDLE = 1'b0, SECOND = 1'b1} state_t;

    state_t state, state_nxt;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] low_buf;

    logic             req, is_store, is_load, legal, misaligned;
    logic [1:0]       off;
    logic [2:0]       size;
    logic [3:0]       size_mask;
    logic [IDX_W-1:0] idx_a, idx_b;
    logic [63:0]      st_wide;
    logic [7:0]       be_wide;
    logic [31:0]      word_a, word_b;
    logic [4:0]       hi_sh;

    logic             wr_en, buf_load;
    logic [IDX_W-1:0] wr_idx;
    logic [3:0]       wr_be;
    logic [31:0]      wr_data, buf_nxt, ld, raw;
    logic             stall, err;

    logic unused_addr;
    assign unused_addr = ^bus.addr[31:IDX_W+2];

    function automatic logic [31:0] extend(input logic [2:0] t, input logic [31:0] r);
        case (t)
            3'b000:  extend = {{24{r[7]}}, r[7:0]};
            3'b001:  extend = {{16{r[15]}}, r[15:0]};
            3'b100:  extend = {24'd0, r[7:0]};
            3'b101:  extend = {16'd0, r[15:0]};
            default: extend = r;
        endcase
    endfunction

    // request decode; the store data and byte enables are laid out across a
    // two-word window so the word-A and word-A+1 halves fall out as slices
    always_comb begin
        req      = bus.MemRead | bus.MemWrite;
        is_store = bus.MemWrite;
        is_load  = bus.MemRead & ~bus.MemWrite;
        off      = bus.addr[1:0];
        idx_a    = bus.addr[IDX_W+1:2];
        idx_b    = idx_a + IDX_W'(1);
        legal     = 1'b1;
        size      = 3'd1;
        size_mask = 4'b0001;
        case (bus.RW_type)
            3'b000, 3'b100: begin size = 3'd1; size_mask = 4'b0001; end
            3'b001, 3'b101: begin size = 3'd2; size_mask = 4'b0011; end
            3'b010:         begin size = 3'd4; size_mask = 4'b1111; end
            default:        begin legal = 1'b0; size_mask = 4'b0000; end
        endcase
        misaligned = ({2'b00, off} + {1'b0, size}) > 4'd4;
        st_wide    = {32'd0, bus.Wr_mem_data} << {off, 3'b000};
        be_wide    = {4'd0, size_mask} << off;
        word_a     = mem[idx_a];
        word_b     = mem[idx_b];
        // (4 - off) bytes, expressed as a 5-bit bit-shift
        hi_sh      = 5'd0 - {off, 3'b000};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            low_buf <= '0;
        end else begin
            state <= state_nxt;
            if (buf_load) low_buf <= buf_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        if (state == IDLE && req && legal && misaligned) state_nxt = SECOND;
    end

    always_comb begin
        wr_en    = 1'b0;
        wr_idx   = idx_a;
        wr_be    = be_wide[3:0];
        wr_data  = st_wide[31:0];
        buf_load = 1'b0;
        buf_nxt  = word_a >> {off, 3'b000};
        raw      = 32'd0;
        ld       = 32'd0;
        stall    = 1'b0;
        err      = 1'b0;
        if (rst_n && req) begin
            if (!legal) begin
                err = 1'b1;
            end else if (state == IDLE) begin
                wr_en = is_store;
                if (misaligned) begin
                    stall    = 1'b1;
                    buf_load = 1'b1;
                end else if (is_load) begin
                    raw = word_a >> {off, 3'b000};
                    ld  = extend(bus.RW_type, raw);
                end
            end else if (misaligned) begin
                // a request that no longer looks misaligned is treated as
                // dropped: no second-half write, no load result
                wr_en   = is_store;
                wr_idx  = idx_b;
                wr_be   = be_wide[7:4];
                wr_data = st_wide[63:32];
                if (is_load) begin
                    raw = low_buf | (word_b << hi_sh);
                    ld  = extend(bus.RW_type, raw);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    assign bus.loaddata   = ld;
    assign bus.mem_stall  = stall;
    assign bus.access_err = err;
endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
    localparam logic [2:0] T_B  = 3'b000;
    localparam logic [2:0] T_H  = 3'b001;
    localparam logic [2:0] T_W  = 3'b010;
    localparam logic [2:0] T_BU = 3'b100;
    localparam logic [2:0] T_HU = 3'b101;

    localparam int K_TXN  = 0;
    localparam int K_RST  = 1;
    localparam int K_IDLE = 2;

    typedef struct {
        int          kind;
        string       name;
        logic [31:0] ld;
        logic        err;
        int          stalls;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail = 0;
    int   stall_cnt = 0;
    exp_t sb[$];

    dmem_if bus ();

    dmem_responder #(.DEPTH_WORDS(256)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // monitor: pops the scoreboard whenever the DUT presents a result
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            stall_cnt = 0;
            if (sb.size() > 0 && sb[0].kind == K_RST) begin
                e = sb.pop_front();
                chk32({e.name, "_loaddata"}, bus.loaddata, 32'd0);
                chk32({e.name, "_stall"}, {31'd0, bus.mem_stall}, 32'd0);
                chk32({e.name, "_err"}, {31'd0, bus.access_err}, 32'd0);
            end
        end else if (bus.MemRead || bus.MemWrite) begin
            if (bus.mem_stall) begin
                stall_cnt++;
            end else begin
                if (sb.size() == 0 || sb[0].kind != K_TXN) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_completion: got completion at addr 0x%08h, expected none", bus.addr);
                end else begin
                    e = sb.pop_front();
                    chk32({e.name, "_loaddata"}, bus.loaddata, e.ld);
                    chk32({e.name, "_err"}, {31'd0, bus.access_err}, {31'd0, e.err});
                    chk32({e.name, "_stalls"}, 32'(stall_cnt), 32'(e.stalls));
                end
                stall_cnt = 0;
            end
        end else begin
            stall_cnt = 0;
            if (sb.size() > 0 && sb[0].kind == K_IDLE) begin
                e = sb.pop_front();
                chk32({e.name, "_loaddata"}, bus.loaddata, 32'd0);
                chk32({e.name, "_stall"}, {31'd0, bus.mem_stall}, 32'd0);
                chk32({e.name, "_err"}, {31'd0, bus.access_err}, 32'd0);
            end
        end
    end

    task automatic drive(input logic rd, input logic wr, input logic [2:0] t,
                         input logic [31:0] a, input logic [31:0] d);
        bus.MemRead     = rd;
        bus.MemWrite    = wr;
        bus.RW_type     = t;
        bus.addr        = a;
        bus.Wr_mem_data = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, T_W, 32'd0, 32'd0);
    endtask

    task automatic push(input int kind, input string nm, input logic [31:0] ld,
                        input logic err, input int st);
        exp_t e;
        e.kind   = kind;
        e.name   = nm;
        e.ld     = ld;
        e.err    = err;
        e.stalls = st;
        sb.push_back(e);
    endtask

    // holds the request until the DUT releases mem_stall, like the pipeline
    task automatic txn(input string nm, input logic rd, input logic wr, input logic [2:0] t,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_ld, input logic exp_err, input int exp_st);
        bit done;
        done = 1'b0;
        push(K_TXN, nm, exp_ld, exp_err, exp_st);
        drive(rd, wr, t, a, d);
        for (int k = 0; k < 8 && !done; k++) begin
            @(negedge clk);
            if (!bus.mem_stall) done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: mem_stall still 1 after 8 cycles, expected 0", nm);
        end
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic st(input string nm, input logic [2:0] t, input logic [31:0] a,
                      input logic [31:0] d, input int exp_st);
        txn(nm, 1'b0, 1'b1, t, a, d, 32'd0, 1'b0, exp_st);
    endtask

    task automatic ld(input string nm, input logic [2:0] t, input logic [31:0] a,
                      input logic [31:0] exp_ld, input int exp_st);
        txn(nm, 1'b1, 1'b0, t, a, 32'd0, exp_ld, 1'b0, exp_st);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "global timeout");
    end

    initial begin
        rst_n = 1'b0;
        drive(1'b1, 1'b0, T_W, 32'h10, 32'd0);
        push(K_RST, "reset_a", 32'd0, 1'b0, 0);
        push(K_RST, "reset_b", 32'd0, 1'b0, 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();

        st("sw_010", T_W, 32'h010, 32'h12345678, 0);
        ld("lw_010", T_W, 32'h010, 32'h12345678, 0);
        ld("lb_013", T_B, 32'h013, 32'h00000012, 0);
        ld("lhu_010", T_HU, 32'h010, 32'h00005678, 0);
        ld("lh_012", T_H, 32'h012, 32'h00001234, 0);

        st("sw_020", T_W, 32'h020, 32'h44332211, 0);
        st("sb_021", T_B, 32'h021, 32'hFFFFFF80, 0);
        ld("lb_021", T_B, 32'h021, 32'hFFFFFF80, 0);
        ld("lbu_021", T_BU, 32'h021, 32'h00000080, 0);
        ld("lw_020", T_W, 32'h020, 32'h44338011, 0);

        st("sw_004", T_W, 32'h004, 32'h0, 0);
        st("sw_008", T_W, 32'h008, 32'h0, 0);
        st("sw_mis_006", T_W, 32'h006, 32'hAABBCCDD, 1);
        ld("lw_004", T_W, 32'h004, 32'hCCDD0000, 0);
        ld("lw_008", T_W, 32'h008, 32'h0000AABB, 0);
        ld("lw_mis_006", T_W, 32'h006, 32'hAABBCCDD, 1);
        ld("lh_mis_007", T_H, 32'h007, 32'hFFFFBBCC, 1);
        ld("lhu_mis_007", T_HU, 32'h007, 32'h0000BBCC, 1);

        st("sw_3fc", T_W, 32'h3FC, 32'h01020304, 0);
        st("sw_000", T_W, 32'h000, 32'hA0B0C0D0, 0);
        st("sh_wrap_3ff", T_H, 32'h3FF, 32'h0000BEEF, 1);
        ld("lbu_3ff", T_BU, 32'h3FF, 32'h000000EF, 0);
        ld("lbu_000", T_BU, 32'h000, 32'h000000BE, 0);
        ld("lw_3fc", T_W, 32'h3FC, 32'hEF020304, 0);
        ld("lw_000", T_W, 32'h000, 32'hA0B0C0BE, 0);
        ld("lh_wrap_3ff", T_H, 32'h3FF, 32'hFFFFBEEF, 1);
        ld("lw_wrap_3fe", T_W, 32'h3FE, 32'hC0BEEF02, 1);

        // reset while the second half of a misaligned store is pending
        st("sw_00c", T_W, 32'h00C, 32'h0, 0);
        push(K_RST, "rst_in_second", 32'd0, 1'b0, 0);
        drive(1'b0, 1'b1, T_W, 32'h00E, 32'h11223344);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        ld("lw_00c_after_rst", T_W, 32'h00C, 32'h33440000, 0);
        ld("lw_010_after_rst", T_W, 32'h010, 32'h12345678, 0);

        st("sw_040", T_W, 32'h040, 32'hCAFEF00D, 0);
        txn("illegal_st_011", 1'b0, 1'b1, 3'b011, 32'h040, 32'hFFFFFFFF, 32'd0, 1'b1, 0);
        txn("illegal_ld_110", 1'b1, 1'b0, 3'b110, 32'h040, 32'd0, 32'd0, 1'b1, 0);
        txn("illegal_ld_111", 1'b1, 1'b0, 3'b111, 32'h041, 32'd0, 32'd0, 1'b1, 0);
        ld("lw_040", T_W, 32'h040, 32'hCAFEF00D, 0);

        txn("rdwr_sw_050", 1'b1, 1'b1, T_W, 32'h050, 32'h5555AAAA, 32'd0, 1'b0, 0);
        ld("lw_050", T_W, 32'h050, 32'h5555AAAA, 0);
        txn("rdwr_sh_mis_053", 1'b1, 1'b1, T_H, 32'h053, 32'h00001234, 32'd0, 1'b0, 1);
        ld("lw_050_b", T_W, 32'h050, 32'h3455AAAA, 0);
        ld("lbu_054", T_BU, 32'h054, 32'h00000012, 0);

        // request dropped while in the second cycle
        st("sw_05c", T_W, 32'h05C, 32'h0, 0);
        st("sw_060", T_W, 32'h060, 32'h0, 0);
        push(K_IDLE, "drop_in_second", 32'd0, 1'b0, 0);
        drive(1'b0, 1'b1, T_W, 32'h05E, 32'h99887766);
        @(negedge clk);
        @(posedge clk);
        #1;
        idle();
        @(negedge clk);
        @(posedge clk);
        #1;
        ld("lw_05c_drop", T_W, 32'h05C, 32'h77660000, 0);
        ld("lw_060_drop", T_W, 32'h060, 32'h00000000, 0);

        // stores presented during reset must not land; reset keeps the array
        st("sw_070", T_W, 32'h070, 32'h0BADF00D, 0);
        push(K_RST, "rst_store_a", 32'd0, 1'b0, 0);
        push(K_RST, "rst_store_b", 32'd0, 1'b0, 0);
        drive(1'b0, 1'b1, T_W, 32'h070, 32'hFFFFFFFF);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        ld("lw_070_after_rst", T_W, 32'h070, 32'h0BADF00D, 0);
        ld("lw_020_after_rst", T_W, 32'h020, 32'h44338011, 0);

        repeat (2) @(negedge clk);
        chk32("scoreboard_drain", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
